vga_timing_recovery: RTL and testbench

VGA_TIMING_RECOVERY -- requirements
Module: vga_timing_recovery

---
 rtl/vga_timing_recovery.sv | 155 +++++++++++++++
 tb/tb_vga_timing_recovery.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_recovery.sv
// rtl/vga_timing_recovery.sv - recovers 640x480@60 pixel coordinates and lock status from raw syncs
module vga_timing_recovery (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [8:0]  rgb_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pix_valid,
    output logic [8:0]  rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] h_period,
    output logic [9:0]  v_lines,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t      state, state_next;
    logic [1:0]  good, good_next;
    logic        hs_d, vs_d;
    logic        h_fall, v_fall;
    logic [9:0]  hc, vc;
    logic [10:0] hp;
    logic [9:0]  vl;
    logic [9:0]  v_meas;
    logic        first_h, first_v, frame_bad;
    logic        h_err, v_err;
    logic        hc_wrap, visible;

    assign h_fall  = hs_d & ~hsync_in;
    assign v_fall  = vs_d & ~vsync_in;
    assign hc_wrap = !h_fall && (hc == 10'd799);
    assign locked  = (state == LOCKED);
    assign visible = locked && (hc < 10'd640) && (vc < 10'd480);

    // A line ending on the same clock as the frame still belongs to the frame being measured
    always_comb begin
        v_meas = vl;
        if (h_fall && (vl != 10'd1023))
            v_meas = vl + 10'd1;
    end

    assign h_err = h_fall && !first_h && (hp != 11'd800);
    assign v_err = v_fall && !first_v && (v_meas != 10'd525);

    always_comb begin
        state_next = state;
        good_next  = good;
        case (state)
            SEARCH: begin
                if (v_fall) begin
                    state_next = ACQUIRE;
                    good_next  = 2'd0;
                end
            end
            ACQUIRE: begin
                if (h_err || v_err) begin
                    good_next = 2'd0;
                end else if (v_fall) begin
                    if (frame_bad) begin
                        good_next = 2'd0;
                    end else if (good == 2'd1) begin
                        good_next  = 2'd2;
                        state_next = LOCKED;
                    end else begin
                        good_next = good + 2'd1;
                    end
                end
            end
            LOCKED: begin
                if (h_err || v_err)
                    state_next = SEARCH;
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            good        <= 2'd0;
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            hc          <= 10'd0;
            vc          <= 10'd0;
            hp          <= 11'd0;
            vl          <= 10'd0;
            first_h     <= 1'b1;
            first_v     <= 1'b1;
            frame_bad   <= 1'b0;
            h_period    <= 11'd0;
            v_lines     <= 10'd0;
            err_count   <= 8'd0;
            x           <= 10'd0;
            y           <= 10'd0;
            pix_valid   <= 1'b0;
            rgb_out     <= 9'd0;
            frame_start <= 1'b0;
        end else begin
            state <= state_next;
            good  <= good_next;
            hs_d  <= hsync_in;
            vs_d  <= vsync_in;

            if (h_fall)
                hc <= 10'd656;
            else if (hc == 10'd799)
                hc <= 10'd0;
            else
                hc <= hc + 10'd1;

            if (v_fall)
                vc <= 10'd490;
            else if (hc_wrap)
                vc <= (vc == 10'd524) ? 10'd0 : vc + 10'd1;

            if (h_fall) begin
                hp       <= 11'd1;
                h_period <= hp;
            end else if (hp != 11'd2047) begin
                hp <= hp + 11'd1;
            end

            if (v_fall) begin
                vl      <= 10'd0;
                v_lines <= v_meas;
            end else if (h_fall && (vl != 10'd1023)) begin
                vl <= vl + 10'd1;
            end

            if (h_fall)
                first_h <= 1'b0;
            if (v_fall)
                first_v <= 1'b0;

            if (v_fall)
                frame_bad <= 1'b0;
            else if (h_err)
                frame_bad <= 1'b1;

            if ((h_err || v_err) && (err_count != 8'd255))
                err_count <= err_count + 8'd1;

            x           <= hc;
            y           <= vc;
            pix_valid   <= visible;
            rgb_out     <= visible ? rgb_in : 9'd0;
            frame_start <= locked && (hc == 10'd0) && (vc == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing_recovery.sv
// tb/tb_vga_timing_recovery.sv - self-checking bench for vga_timing_recovery
module tb_vga_timing_recovery;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync_in;
    logic        vsync_in;
    logic [8:0]  rgb_in;
    logic [9:0]  x, y;
    logic        pix_valid;
    logic [8:0]  rgb_out;
    logic        frame_start;
    logic        locked;
    logic [10:0] h_period;
    logic [9:0]  v_lines;
    logic [7:0]  err_count;

    vga_timing_recovery dut (
        .clk        (clk),
        .reset      (reset),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .rgb_in     (rgb_in),
        .x          (x),
        .y          (y),
        .pix_valid  (pix_valid),
        .rgb_out    (rgb_out),
        .frame_start(frame_start),
        .locked     (locked),
        .h_period   (h_period),
        .v_lines    (v_lines),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       pv;
        logic [8:0] rgb;
        logic       fs;
    } exp_t;

    typedef struct {
        int         col;
        int         line;
        logic [8:0] rgb;
        exp_t       e;
    } probe_t;

    exp_t   sb_q[$];
    probe_t probes[8];
    exp_t   no_exp;
    int     tests = 0;
    int     fails = 0;
    int     gc = 0;
    int     gl = 0;
    int     vfalls = 0;
    bit     prev_vs = 1'b1;
    bit     short_armed = 1'b0;
    bit     skip_armed = 1'b0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Generator column g is seen by the recovered counter one clock later.
    function automatic int map_h();
        return (gc == 0) ? 799 : gc - 1;
    endfunction

    function automatic int map_v();
        if (gc != 0) return gl;
        return (gl == 0) ? 524 : gl - 1;
    endfunction

    function automatic probe_t mk(input int col, input int line, input logic [8:0] rgb,
                                  input int ex, input int ey, input logic pv,
                                  input logic [8:0] orgb, input logic fs);
        probe_t p;
        p.col = col; p.line = line; p.rgb = rgb;
        p.e.x = 10'(ex); p.e.y = 10'(ey); p.e.pv = pv; p.e.rgb = orgb; p.e.fs = fs;
        return p;
    endfunction

    // push_mode: 0 none, 1 expected from generator position (locked), 2 supplied entry
    task automatic tick(input logic [8:0] rgb, input int push_mode, input exp_t tbl_e);
        exp_t e;
        int   hce, vce;
        hsync_in = !(gc >= 656 && gc <= 750);
        vsync_in = (gl != 490);
        rgb_in   = rgb;
        if (!vsync_in && prev_vs) vfalls++;
        prev_vs = vsync_in;
        hce = map_h();
        vce = map_v();
        if (push_mode == 1) begin
            e.x   = 10'(hce);
            e.y   = 10'(vce);
            e.pv  = (hce < 640) && (vce < 480);
            e.rgb = e.pv ? rgb : 9'd0;
            e.fs  = (hce == 0) && (vce == 0);
            sb_q.push_back(e);
        end else if (push_mode == 2) begin
            sb_q.push_back(tbl_e);
        end
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tests++;
            if (x !== e.x || y !== e.y || pix_valid !== e.pv || rgb_out !== e.rgb || frame_start !== e.fs) begin
                fails++;
                $display("FAIL sb_pixel: got x=%0d y=%0d pv=%0b rgb=%h fs=%0b, expected x=%0d y=%0d pv=%0b rgb=%h fs=%0b",
                         x, y, pix_valid, rgb_out, frame_start, e.x, e.y, e.pv, e.rgb, e.fs);
            end
        end
        if (short_armed && gl == 10 && gc == 99) begin
            gc = 101;
            short_armed = 1'b0;
        end else if (gc == 799) begin
            gc = 0;
            if (skip_armed && gl == 100) begin
                gl = 102;
                skip_armed = 1'b0;
            end else begin
                gl = (gl == 524) ? 0 : gl + 1;
            end
        end else begin
            gc++;
        end
    endtask

    task automatic run_vfalls(input int n);
        int target;
        int budget;
        target = vfalls + n;
        budget = 0;
        while (vfalls < target && budget < 500000 * n) begin
            tick(9'd0, 0, no_exp);
            budget++;
        end
        if (vfalls < target) check("vfall_timeout", 0, 1);
    endtask

    task automatic run_to(input int line, input int col);
        int budget;
        budget = 0;
        while (!(gl == line && gc == col) && budget < 500000) begin
            tick(9'd0, 0, no_exp);
            budget++;
        end
        if (budget >= 500000) check("position_timeout", 0, 1);
    endtask

    task automatic drive_n(input logic hs, input logic vs, input int n);
        hsync_in = hs;
        vsync_in = vs;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        probes[0] = mk(700, 500, 9'h1FF, 700, 500, 1'b0, 9'h000, 1'b0);
        probes[1] = mk(799, 524, 9'h1FF, 799, 524, 1'b0, 9'h000, 1'b0);
        probes[2] = mk(0,   0,   9'h123, 0,   0,   1'b1, 9'h123, 1'b1);
        probes[3] = mk(5,   7,   9'h1FF, 5,   7,   1'b1, 9'h1FF, 1'b0);
        probes[4] = mk(700, 7,   9'h1FF, 700, 7,   1'b0, 9'h000, 1'b0);
        probes[5] = mk(639, 479, 9'h0AA, 639, 479, 1'b1, 9'h0AA, 1'b0);
        probes[6] = mk(640, 479, 9'h155, 640, 479, 1'b0, 9'h000, 1'b0);
        probes[7] = mk(5,   480, 9'h1FF, 5,   480, 1'b0, 9'h000, 1'b0);

        reset    = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        rgb_in   = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_locked", locked, 0);
        check("reset_err_count", err_count, 0);
        check("reset_h_period", h_period, 0);
        check("reset_xy", {x, y}, 0);
        reset = 1'b0;

        // Clean stream: SEARCH, then two good frames
        run_vfalls(1);
        check("lock_after_vfall1", locked, 0);
        run_vfalls(1);
        check("lock_after_vfall2", locked, 0);
        run_vfalls(1);
        check("lock_after_vfall3", locked, 1);
        check("clean_h_period", h_period, 800);
        check("clean_v_lines", v_lines, 525);
        check("clean_err_count", err_count, 0);

        // Pixel probes in frame order, with sampled scoreboard traffic in between
        for (int i = 0; i < 8; i++) begin
            budget = 0;
            while (!(map_h() == probes[i].col && map_v() == probes[i].line) && budget < 500000) begin
                tick(9'($urandom_range(0, 511)), (gc % 16 == 1) ? 1 : 0, no_exp);
                budget++;
            end
            if (budget >= 500000) check("probe_timeout", 0, 1);
            tick(probes[i].rgb, 2, probes[i].e);
        end
        check("probe_still_locked", locked, 1);

        // Reset mid-frame while locked
        run_to(200, 10);
        check("pre_reset_locked", locked, 1);
        check("pre_reset_err", err_count, 0);
        reset = 1'b1;
        tick(9'h1FF, 0, no_exp);
        reset = 1'b0;
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_rgb_out", rgb_out, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_locked", locked, 0);
        check("rst_h_period", h_period, 0);
        check("rst_v_lines", v_lines, 0);
        check("rst_err_count", err_count, 0);
        run_vfalls(1);
        check("post_rst_vfall1_err", err_count, 0);
        check("post_rst_vfall1_locked", locked, 0);
        run_vfalls(1);
        check("post_rst_vfall2_locked", locked, 0);
        run_vfalls(1);
        check("post_rst_relock", locked, 1);
        check("post_rst_err", err_count, 0);

        // One line shortened to 799 clocks
        short_armed = 1'b1;
        run_to(10, 656);
        check("short_pre_locked", locked, 1);
        tick(9'd0, 0, no_exp);
        check("short_h_period", h_period, 799);
        check("short_err_count", err_count, 1);
        check("short_locked_drop", locked, 0);
        run_vfalls(1);
        check("short_relock1", locked, 0);
        run_vfalls(1);
        check("short_relock2", locked, 0);
        run_vfalls(1);
        check("short_relock3", locked, 1);
        check("short_err_stable", err_count, 1);
        check("short_h_period_back", h_period, 800);

        // A 524-line frame
        skip_armed = 1'b1;
        run_vfalls(1);
        check("short_frame_v_lines", v_lines, 524);
        check("short_frame_err", err_count, 2);
        check("short_frame_unlocked", locked, 0);

        // Stuck-high hsync saturates the period counter, then an error storm saturates err_count
        drive_n(1'b1, 1'b1, 3000);
        drive_n(1'b0, 1'b1, 1);
        check("sat_h_period", h_period, 2047);
        check("sat_err_count", err_count, 3);
        for (int i = 0; i < 300; i++) begin
            drive_n(1'b1, 1'b1, 9);
            drive_n(1'b0, 1'b1, 1);
            if (i == 99) check("storm_err_mid", err_count, 103);
        end
        check("storm_h_period", h_period, 10);
        check("storm_err_sat", err_count, 255);
        check("storm_locked", locked, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
